// File: rtl/int_to_fp_flopoco_pipe.sv
// Integer to FloPoCo float converter: 4-stage pipeline (abs, lzc, normalize, round/pack)
// with valid/ready flow control and a global clock enable.
module int_to_fp_flopoco_pipe #(
  parameter int IN_WIDTH = 32,
  parameter int WE       = 8,
  parameter int WF       = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_signed,
  input  logic [IN_WIDTH-1:0] I,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WE+WF+2:0]    O
);

  localparam int LZW = $clog2(IN_WIDTH + 1);
  localparam logic [WE-1:0] BIAS = WE'((2 ** (WE - 1)) - 1);

  if (IN_WIDTH < 2 || WF < 1 || ((2 ** (WE - 1)) - 1) < IN_WIDTH) begin : g_bad_params
    $error("int_to_fp_flopoco_pipe: illegal IN_WIDTH/WE/WF combination");
  end

  logic stall;

  logic                v1_q, v1_d, sign1_q, sign1_d;
  logic [IN_WIDTH-1:0] mag1_q, mag1_d;

  logic                v2_q, v2_d, sign2_q, sign2_d, zero2_q, zero2_d;
  logic [LZW-1:0]      lz2_q, lz2_d;
  logic [IN_WIDTH-2:0] mag2_q, mag2_d;

  logic                v3_q, v3_d, sign3_q, sign3_d, zero3_q, zero3_d;
  logic [WE-1:0]       exp3_q, exp3_d;
  logic [IN_WIDTH-2:0] norm3_q, norm3_d;

  logic                v4_q, v4_d;
  logic [WE+WF+2:0]    o4_q, o4_d;

  logic [WF-1:0]       frac_r;
  logic                carry_r;

  assign stall     = ~ce | (v4_q & ~out_ready);
  assign in_ready  = ~stall;
  assign out_valid = v4_q;
  assign O         = o4_q;

  always_comb begin
    v1_d    = in_valid;
    sign1_d = in_signed & I[IN_WIDTH-1];
    mag1_d  = sign1_d ? -I : I;
  end

  // The magnitude MSB only matters for the count; later stages keep the bits below it.
  always_comb begin
    v2_d    = v1_q;
    sign2_d = sign1_q;
    zero2_d = (mag1_q == '0);
    mag2_d  = mag1_q[IN_WIDTH-2:0];
    lz2_d   = LZW'(IN_WIDTH);
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (mag1_q[i]) lz2_d = LZW'(IN_WIDTH - 1 - i);
    end
  end

  always_comb begin
    v3_d    = v2_q;
    sign3_d = sign2_q;
    zero3_d = zero2_q;
    norm3_d = mag2_q << lz2_q;
    exp3_d  = WE'(IN_WIDTH - 1) - WE'(lz2_q);
  end

  if (IN_WIDTH - 1 <= WF) begin : g_exact
    always_comb begin
      frac_r = '0;
      frac_r[WF-1 -: IN_WIDTH-1] = norm3_q;
      carry_r = 1'b0;
    end
  end else begin : g_rne
    localparam int D = IN_WIDTH - 1 - WF;
    logic          guard, sticky, inc;
    logic [WF:0]   sum;
    always_comb begin
      guard  = norm3_q[D-1];
      sticky = 1'b0;
      for (int i = 0; i < D - 1; i++) sticky = sticky | norm3_q[i];
      inc     = guard & (sticky | norm3_q[D]);
      sum     = {1'b0, norm3_q[IN_WIDTH-2:D]} + {{WF{1'b0}}, inc};
      frac_r  = sum[WF-1:0];
      carry_r = sum[WF];
    end
  end

  // A rounding carry leaves frac at zero, so only the exponent needs the bump.
  always_comb begin
    v4_d = v3_q;
    o4_d = zero3_q ? '0 : {2'b01, sign3_q, exp3_q + BIAS + WE'(carry_r), frac_r};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      mag1_q  <= '0;
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      zero2_q <= 1'b0;
      lz2_q   <= '0;
      mag2_q  <= '0;
      v3_q    <= 1'b0;
      sign3_q <= 1'b0;
      zero3_q <= 1'b0;
      exp3_q  <= '0;
      norm3_q <= '0;
      v4_q    <= 1'b0;
      o4_q    <= '0;
    end else if (!stall) begin
      v1_q    <= v1_d;
      sign1_q <= sign1_d;
      mag1_q  <= mag1_d;
      v2_q    <= v2_d;
      sign2_q <= sign2_d;
      zero2_q <= zero2_d;
      lz2_q   <= lz2_d;
      mag2_q  <= mag2_d;
      v3_q    <= v3_d;
      sign3_q <= sign3_d;
      zero3_q <= zero3_d;
      exp3_q  <= exp3_d;
      norm3_q <= norm3_d;
      v4_q    <= v4_d;
      o4_q    <= o4_d;
    end
  end

endmodule

// File: tb/tb_int_to_fp_flopoco_pipe.sv
// Bench for int_to_fp_flopoco_pipe: arithmetic reference model, in-order scoreboard
// with latency tracking, directed vectors, backpressure/ce windows, reset mid-flight.
module tb_int_to_fp_flopoco_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_signed = 1'b0;
  logic [31:0] I = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [33:0] O;

  int total = 0;
  int passed = 0;

  int_to_fp_flopoco_pipe #(.IN_WIDTH(32), .WE(8), .WF(23)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .I(I), .out_valid(out_valid), .out_ready(out_ready), .O(O)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: find the leading one, compare the dropped remainder against half an ulp.
  function automatic logic [33:0] model(input logic [31:0] x, input logic s);
    logic   neg;
    longint mag, q, rem, half;
    int     e, sh;
    logic [22:0] fr;
    neg = s && x[31];
    mag = neg ? (longint'(1) << 32) - longint'({32'b0, x}) : longint'({32'b0, x});
    if (mag == 0) return 34'h0;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      fr = 23'((mag - (longint'(1) << e)) << (23 - e));
    end else begin
      sh   = e - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
      fr = 23'(q - (longint'(1) << 23));
    end
    return {2'b01, neg, 8'(e + 127), fr};
  endfunction

  typedef struct {
    logic [33:0] o;
    int          adv;
  } ent_t;
  ent_t sb[$];

  int   adv = 0;
  bit   have_prev = 0;
  bit   prev_stall = 0;
  logic prev_valid;
  logic [33:0] prev_o;
  bit   stall_m;
  ent_t e;

  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      have_prev = 0;
    end else begin
      stall_m = !ce || (out_valid && !out_ready);
      chk("in_ready", in_ready, !stall_m);
      if (have_prev && prev_stall) begin
        chk("hold_valid", out_valid, prev_valid);
        chk("hold_O", O, prev_o);
      end
      if (ce && out_valid && out_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("O", O, e.o);
          chk("latency", 64'(adv - e.adv), 4);
        end
      end
      if (in_valid && in_ready) sb.push_back('{model(I, in_signed), adv});
      if (!stall_m) adv++;
      prev_stall = stall_m;
      prev_valid = out_valid;
      prev_o     = O;
      have_prev  = 1;
    end
  end

  int mode = 0;
  int cyc = 0;
  int hs = 0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    case (mode)
      0: begin out_ready = 1'b1; ce = 1'b1; end
      1: begin ce = 1'b1; out_ready = !(cyc >= hs && cyc < hs + 5); end
      2: begin out_ready = 1'b1; ce = !((cyc >= hs && cyc < hs + 5) || cyc == hs + 8); end
      default: begin
        out_ready = ($urandom_range(0, 3) != 0);
        ce        = ($urandom_range(0, 7) != 0);
      end
    endcase
  end

  task automatic send(input logic s, input logic [31:0] x);
    bit acc = 0;
    int n = 0;
    in_valid  = 1'b1;
    in_signed = s;
    I         = x;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accepted", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    I         = $urandom;
    in_signed = 1'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return 32'($urandom_range(0, 255));
      2: return 32'(1) << $urandom_range(0, 31);
      3: return ($urandom & 32'hFFFF_FF00) | 32'h80;
      4: return 32'hFFFF_FFFF - 32'($urandom_range(0, 300));
      default: return 32'h8000_0000 + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_O", O, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    chk("m_one",    model(32'h1, 0),          34'h1_3F80_0000);
    chk("m_zero",   model(32'h0, 0),          34'h0_0000_0000);
    chk("m_ffff_u", model(32'hFFFF_FFFF, 0),  34'h1_4F80_0000);
    chk("m_ffff_s", model(32'hFFFF_FFFF, 1),  34'h1_BF80_0000);
    chk("m_tie1",   model(32'h0100_0001, 0),  34'h1_4B80_0000);
    chk("m_tie3",   model(32'h0100_0003, 0),  34'h1_4B80_0002);
    chk("m_tie5",   model(32'h0100_0005, 0),  34'h1_4B80_0002);
    chk("m_min_s",  model(32'h8000_0000, 1),  34'h1_CF00_0000);
    chk("m_min_u",  model(32'h8000_0000, 0),  34'h1_4F00_0000);

    mode = 0;
    send(0, 32'h1);
    send(0, 32'h0);
    send(0, 32'hFFFF_FFFF);
    send(1, 32'hFFFF_FFFF);
    send(0, 32'h0100_0001);
    send(0, 32'h0100_0003);
    send(0, 32'h0100_0005);
    send(1, 32'h8000_0000);
    send(0, 32'h8000_0000);
    send(1, 32'h0);
    idle(8);

    mode = 1;
    hs = cyc + 6;
    for (int k = 0; k < 8; k++) send(1'($urandom), pick());
    idle(15);

    mode = 2;
    hs = cyc + 4;
    for (int k = 0; k < 8; k++) send(1'($urandom), pick());
    idle(20);

    mode = 0;
    for (int k = 0; k < 5; k++) send(0, 32'h100 + 32'(k));
    #2;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_O", O, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(8);
    send(0, 32'h1234_5678);
    idle(8);

    mode = 3;
    for (int k = 0; k < 300; k++) begin
      send(1'($urandom), pick());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    mode = 0;
    idle(1);
    for (int k = 0; k < 50 && sb.size() != 0; k++) idle(1);
    chk("drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
